bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Shares the single core memory bus between two requesters: M0 is instruction fetch, M1 is load/store.
- Round-robin arbitration, one new bus transaction per cycle.
- Reads are pipelined against a fixed-latency bus.
- Returns read data to the requester that issued each read, using an in-flight owner-tag shift register.

Parameters:
- BUS_WIDTH, 32, bus data width.
- AD_LEN, 32, bus address width.
- RD_LATENCY, 2, cycles from the bus address cycle until bus_data_i is valid. Minimum 1.

Ports:
- clk_i  in  1  clock.
- reset_ni  in  1  reset, asynchronous assert, active-low.
- req_i  in  2  per-master request; bit k = master k.
- we_i  in  2  per-master write enable; 0 = read.
- ad0_i  in  AD_LEN  M0 address.
- ad1_i  in  AD_LEN  M1 address.
- wdata0_i  in  BUS_WIDTH  M0 write data.
- wdata1_i  in  BUS_WIDTH  M1 write data.
- gnt_o  out  2  combinational one-hot grant for the current cycle.
- rvalid_o  out  2  registered one-cycle read-data-valid pulse, per master.
- rdata_o  out  BUS_WIDTH  registered read data; meaningful only when an rvalid_o bit is set.
- bus_valid_o  out  1  registered address strobe.
- bus_we_o  out  1  registered write enable.
- bus_ad_o  out  AD_LEN  registered bus address.
- bus_wdata_o  out  BUS_WIDTH  registered bus write data.
- bus_data_i  in  BUS_WIDTH  bus read data.

Behaviour:
- Reset (reset_ni low, asynchronous):
  - All registered outputs are 0.
  - Round-robin pointer: last-granted = M1, so M0 wins the first contention.
  - Tag pipeline is cleared.
- Arbitration (combinational in cycle t):
  - If only one req_i bit is set, that master is granted.
  - If both are set, the master not last granted wins.
  - If none are set, gnt_o = 0.
  - gnt_o is always one-hot or zero and never depends on rvalid or pipeline state.
- Pointer update: at the end of cycle t, only when a grant occurred.
- Master rules:
  - A master holds req/we/ad/wdata stable until it sees gnt.
  - A master may keep req high after gnt for a back-to-back request. The arbiter treats it as a new request.
- Address phase (cycle t+1, registered at the end of t):
  - bus_valid_o = 1 and bus_ad_o/bus_we_o/bus_wdata_o come from the winner.
  - With no grant: bus_valid_o = 0, and the other bus outputs hold their previous values.
- Writes:
  - Complete in the address cycle.
  - Produce no rvalid and no tag entry.
  - gnt_o is the only acknowledgement.
- Reads:
  - Push {valid=1, owner=k} into a RD_LATENCY-deep tag shift register, advanced every cycle.
  - Non-read cycles push valid=0.
  - When the tag leaving the last stage is valid, sample bus_data_i in that cycle (t+1+RD_LATENCY).
  - rdata_o and rvalid_o[owner] are registered, so the pulse appears in cycle t+2+RD_LATENCY.
  - Default latency is gnt at t → rvalid at t+4.
- Throughput:
  - Up to one read return per cycle.
  - Back-to-back reads from alternating masters return in grant order, each to its own owner.
- Simultaneous events: a new grant and a read return in the same cycle are independent and both proceed.
- Reset mid-flight: all in-flight tags are discarded, no rvalid pulse is emitted after reset, and pending requests must be re-issued.
- Stability: rvalid_o is never set for both masters in the same cycle.
- Out-of-order returns are impossible; no outstanding-request counter is needed.

Decomposition:
- Package skywave_bus_pkg holds:
  - Master-id constants MST_FETCH=0, MST_LSU=1.
  - A typedef for the tag entry struct {valid, owner}.
  - Default RD_LATENCY.
- Sub-module rr_arb2 contains the 2-way round-robin arbiter: combinational grant plus the registered last-granted pointer.
- bus_arbiter instantiates rr_arb2 and holds the bus registers and the tag pipeline.

Test Plan:
1. Reset, then M0 alone reads ad0=0x100, with the bus model returning 0xDEADBEEF 2 cycles after the address:
   - gnt_o = 01 at t.
   - bus_valid_o = 1 and bus_ad_o = 0x100 at t+1.
   - rvalid_o = 01 with rdata_o = 0xDEADBEEF at t+4.
2. Both masters hold read req for 4 cycles:
   - Grants are 01, 10, 01, 10.
   - Four rvalid pulses in the same order, each carrying data matching its address.
3. M1 writes ad1=0x200, wdata1=0x55 while M0 idles:
   - gnt_o = 10.
   - Next cycle bus_we_o = 1, bus_ad_o = 0x200, bus_wdata_o = 0x55.
   - No rvalid pulse follows.
4. Interleaved M0 read, M1 write, M0 read on consecutive cycles:
   - Exactly two rvalid_o = 01 pulses, 2 cycles apart.
   - The write cycle produces no pulse.
5. M0 read granted, then reset_ni pulsed low 1 cycle later:
   - All outputs are 0 immediately (asynchronous).
   - No rvalid ever appears.
   - The first grant after reset goes to M0 under contention.
6. Idle for 10 cycles:
   - gnt_o = 00 and bus_valid_o = 0 throughout.
   - bus_ad_o holds its last value.

Source files
------------

// File: rtl/skywave_bus_pkg.sv
// Shared definitions for the core memory bus: master ids, the in-flight read tag
// and the default bus read latency.
package skywave_bus_pkg;

   localparam logic MST_FETCH      = 1'b0;
   localparam logic MST_LSU        = 1'b1;
   localparam int   RD_LATENCY_DEF = 2;

   typedef struct packed {
      logic valid;
      logic owner;
   } tag_t;

   function automatic logic [1:0] mst_onehot(input logic owner);
      return owner ? 2'b10 : 2'b01;
   endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: combinational one-hot grant and a registered
// last-granted pointer that only moves when a grant is issued.
module rr_arb2
   import skywave_bus_pkg::*;
(
   input  logic       clk_i,
   input  logic       reset_ni,
   input  logic [1:0] req_i,
   output logic [1:0] gnt_o
);

   logic last_q;
   logic last_d;

   always_comb begin
      gnt_o = 2'b00;
      case (req_i)
         2'b01:   gnt_o = 2'b01;
         2'b10:   gnt_o = 2'b10;
         // Under contention the master that was not served last wins.
         2'b11:   gnt_o = (last_q == MST_LSU) ? 2'b01 : 2'b10;
         default: gnt_o = 2'b00;
      endcase

      last_d = last_q;
      if (gnt_o[0]) begin
         last_d = MST_FETCH;
      end else if (gnt_o[1]) begin
         last_d = MST_LSU;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         last_q <= MST_LSU;
      end else begin
         last_q <= last_d;
      end
   end

endmodule

// File: rtl/bus_arbiter.sv
// Shares the core memory bus between instruction fetch (M0) and load/store (M1);
// reads are pipelined and returned to their issuer through an owner-tag pipeline.
module bus_arbiter
   import skywave_bus_pkg::*;
#(
   parameter int BUS_WIDTH  = 32,
   parameter int AD_LEN     = 32,
   parameter int RD_LATENCY = RD_LATENCY_DEF
) (
   input  logic                 clk_i,
   input  logic                 reset_ni,
   input  logic [1:0]           req_i,
   input  logic [1:0]           we_i,
   input  logic [AD_LEN-1:0]    ad0_i,
   input  logic [AD_LEN-1:0]    ad1_i,
   input  logic [BUS_WIDTH-1:0] wdata0_i,
   input  logic [BUS_WIDTH-1:0] wdata1_i,
   output logic [1:0]           gnt_o,
   output logic [1:0]           rvalid_o,
   output logic [BUS_WIDTH-1:0] rdata_o,
   output logic                 bus_valid_o,
   output logic                 bus_we_o,
   output logic [AD_LEN-1:0]    bus_ad_o,
   output logic [BUS_WIDTH-1:0] bus_wdata_o,
   input  logic [BUS_WIDTH-1:0] bus_data_i
);

   logic [1:0] gnt;

   rr_arb2 u_rr_arb2 (
      .clk_i    (clk_i),
      .reset_ni (reset_ni),
      .req_i    (req_i),
      .gnt_o    (gnt)
   );

   assign gnt_o = gnt;

   logic                 bus_valid_q, bus_valid_d;
   logic                 bus_we_q,    bus_we_d;
   logic [AD_LEN-1:0]    bus_ad_q,    bus_ad_d;
   logic [BUS_WIDTH-1:0] bus_wdata_q, bus_wdata_d;
   logic                 bus_owner_q, bus_owner_d;

   tag_t                 tag_q [RD_LATENCY];
   tag_t                 tag_d [RD_LATENCY];
   tag_t                 tag_out;

   logic [1:0]           rvalid_q, rvalid_d;
   logic [BUS_WIDTH-1:0] rdata_q,  rdata_d;

   always_comb begin
      bus_valid_d = |gnt;
      bus_we_d    = bus_we_q;
      bus_ad_d    = bus_ad_q;
      bus_wdata_d = bus_wdata_q;
      bus_owner_d = bus_owner_q;
      if (gnt[0]) begin
         bus_we_d    = we_i[0];
         bus_ad_d    = ad0_i;
         bus_wdata_d = wdata0_i;
         bus_owner_d = MST_FETCH;
      end else if (gnt[1]) begin
         bus_we_d    = we_i[1];
         bus_ad_d    = ad1_i;
         bus_wdata_d = wdata1_i;
         bus_owner_d = MST_LSU;
      end
   end

   // The tag enters during the address cycle, so after RD_LATENCY stages the
   // last stage lines up with the cycle in which bus_data_i is valid.
   always_comb begin
      tag_d[0].valid = bus_valid_q & ~bus_we_q;
      tag_d[0].owner = bus_owner_q;
      for (int i = 1; i < RD_LATENCY; i++) begin
         tag_d[i] = tag_q[i-1];
      end
      tag_out = tag_q[RD_LATENCY-1];

      rvalid_d = 2'b00;
      rdata_d  = rdata_q;
      if (tag_out.valid) begin
         rvalid_d = mst_onehot(tag_out.owner);
         rdata_d  = bus_data_i;
      end
   end

   always_ff @(posedge clk_i or negedge reset_ni) begin
      if (!reset_ni) begin
         bus_valid_q <= 1'b0;
         bus_we_q    <= 1'b0;
         bus_ad_q    <= '0;
         bus_wdata_q <= '0;
         bus_owner_q <= MST_FETCH;
         for (int i = 0; i < RD_LATENCY; i++) begin
            tag_q[i] <= '0;
         end
         rvalid_q    <= 2'b00;
         rdata_q     <= '0;
      end else begin
         bus_valid_q <= bus_valid_d;
         bus_we_q    <= bus_we_d;
         bus_ad_q    <= bus_ad_d;
         bus_wdata_q <= bus_wdata_d;
         bus_owner_q <= bus_owner_d;
         for (int i = 0; i < RD_LATENCY; i++) begin
            tag_q[i] <= tag_d[i];
         end
         rvalid_q    <= rvalid_d;
         rdata_q     <= rdata_d;
      end
   end

   assign bus_valid_o = bus_valid_q;
   assign bus_we_o    = bus_we_q;
   assign bus_ad_o    = bus_ad_q;
   assign bus_wdata_o = bus_wdata_q;
   assign rvalid_o    = rvalid_q;
   assign rdata_o     = rdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: table-driven grant/bus vectors, a fixed-latency bus
// model and a scoreboard of expected read returns.
module tb_bus_arbiter;

   localparam int RD_LATENCY = 2;

   logic        clk = 1'b0;
   logic        reset_ni = 1'b0;
   logic [1:0]  req_i = 2'b00;
   logic [1:0]  we_i = 2'b00;
   logic [31:0] ad0_i = '0, ad1_i = '0, wdata0_i = '0, wdata1_i = '0;
   logic [1:0]  gnt_o, rvalid_o;
   logic [31:0] rdata_o, bus_ad_o, bus_wdata_o, bus_data_i;
   logic        bus_valid_o, bus_we_o;

   bus_arbiter #(.BUS_WIDTH(32), .AD_LEN(32), .RD_LATENCY(RD_LATENCY)) dut (
      .clk_i(clk), .reset_ni(reset_ni), .req_i(req_i), .we_i(we_i),
      .ad0_i(ad0_i), .ad1_i(ad1_i), .wdata0_i(wdata0_i), .wdata1_i(wdata1_i),
      .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
      .bus_valid_o(bus_valid_o), .bus_we_o(bus_we_o), .bus_ad_o(bus_ad_o),
      .bus_wdata_o(bus_wdata_o), .bus_data_i(bus_data_i)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  req, we;
      logic [31:0] ad0, ad1, wd0, wd1;
      logic [1:0]  gnt;
   } row_t;

   typedef struct {
      logic [1:0]  owner;
      logic [31:0] data;
      int          cyc;
   } sb_t;

   sb_t  sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   cyc = 0;

   logic        e_bv = 1'b0, e_bwe = 1'b0;
   logic [31:0] e_bad = '0, e_bwd = '0;

   function automatic logic [31:0] mem(input logic [31:0] a);
      if (a == 32'h100) return 32'hDEADBEEF;
      return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
   endfunction

   // Bus model: data for an address appears RD_LATENCY cycles after its address cycle.
   logic [31:0] ad_pipe [RD_LATENCY];
   always @(posedge clk) begin
      ad_pipe[0] <= bus_ad_o;
      for (int i = 1; i < RD_LATENCY; i++) ad_pipe[i] <= ad_pipe[i-1];
   end
   assign bus_data_i = mem(ad_pipe[RD_LATENCY-1]);

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Read-return monitor.
   always @(negedge clk) begin
      if (reset_ni && rvalid_o != 2'b00) begin
         n_tests++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_rvalid: got rvalid=%b data=0x%0h, expected no pulse (cycle %0d)",
                     rvalid_o, rdata_o, cyc);
         end else begin
            sb_t e;
            e = sb.pop_front();
            if (rvalid_o !== e.owner || rdata_o !== e.data || cyc != e.cyc) begin
               n_fail++;
               $display("FAIL rvalid_return: got rvalid=%b data=0x%0h cycle=%0d, expected rvalid=%b data=0x%0h cycle=%0d",
                        rvalid_o, rdata_o, cyc, e.owner, e.data, e.cyc);
            end
         end
      end
   end

   function automatic row_t mk(input logic [1:0] req, input logic [1:0] we,
                               input logic [31:0] a0, input logic [31:0] a1,
                               input logic [31:0] w0, input logic [31:0] w1,
                               input logic [1:0] g);
      row_t r;
      r.req = req; r.we = we; r.ad0 = a0; r.ad1 = a1; r.wd0 = w0; r.wd1 = w1; r.gnt = g;
      return r;
   endfunction

   // Drives one cycle of requests, checks the grant and last cycle's bus phase.
   task automatic apply(input row_t r);
      req_i = r.req; we_i = r.we; ad0_i = r.ad0; ad1_i = r.ad1;
      wdata0_i = r.wd0; wdata1_i = r.wd1;
      @(negedge clk);
      chk("gnt", 32'(gnt_o), 32'(r.gnt));
      chk("bus_valid", 32'(bus_valid_o), 32'(e_bv));
      chk("bus_ad", bus_ad_o, e_bad);
      chk("bus_we", 32'(bus_we_o), 32'(e_bwe));
      chk("bus_wdata", bus_wdata_o, e_bwd);
      e_bv = |r.gnt;
      if (r.gnt[0]) begin
         e_bad = r.ad0; e_bwe = r.we[0]; e_bwd = r.wd0;
         if (!r.we[0]) sb.push_back('{2'b01, mem(r.ad0), cyc + 2 + RD_LATENCY});
      end else if (r.gnt[1]) begin
         e_bad = r.ad1; e_bwe = r.we[1]; e_bwd = r.wd1;
         if (!r.we[1]) sb.push_back('{2'b10, mem(r.ad1), cyc + 2 + RD_LATENCY});
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 20) begin
         apply(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
         n++;
      end
      chk("all_reads_returned", 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, "_bus_valid"}, 32'(bus_valid_o), 32'd0);
      chk({tag, "_bus_we"}, 32'(bus_we_o), 32'd0);
      chk({tag, "_bus_ad"}, bus_ad_o, 32'd0);
      chk({tag, "_bus_wdata"}, bus_wdata_o, 32'd0);
      chk({tag, "_rvalid"}, 32'(rvalid_o), 32'd0);
      chk({tag, "_rdata"}, rdata_o, 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   row_t vec[20];

   initial begin
      vec[0]  = mk(2'b01, 2'b00, 32'h100, 0, 0, 0, 2'b01);
      for (int i = 1; i <= 4; i++) vec[i] = mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
      vec[5]  = mk(2'b10, 2'b10, 0, 32'h200, 0, 32'h55, 2'b10);
      for (int i = 6; i <= 8; i++) vec[i] = mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00);
      vec[9]  = mk(2'b11, 2'b00, 32'h110, 32'h210, 0, 0, 2'b01);
      vec[10] = mk(2'b11, 2'b00, 32'h120, 32'h210, 0, 0, 2'b10);
      vec[11] = mk(2'b11, 2'b00, 32'h120, 32'h220, 0, 0, 2'b01);
      vec[12] = mk(2'b11, 2'b00, 32'h130, 32'h220, 0, 0, 2'b10);
      vec[13] = mk(2'b01, 2'b00, 32'h130, 0, 0, 0, 2'b01);
      vec[14] = mk(2'b10, 2'b10, 0, 32'h230, 0, 32'h77, 2'b10);
      vec[15] = mk(2'b01, 2'b00, 32'h140, 0, 0, 0, 2'b01);
      for (int i = 16; i <= 19; i++) vec[i] = mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00);

      // Power-on reset.
      #12;
      chk_zero_outputs("por");
      chk("por_gnt_idle", 32'(gnt_o), 32'd0);
      @(posedge clk);
      #1;
      reset_ni = 1'b1;

      for (int i = 0; i < 20; i++) apply(vec[i]);
      drain();

      // Reset one cycle after a granted read: the read must never return.
      apply(mk(2'b01, 2'b00, 32'h150, 0, 0, 0, 2'b01));
      req_i = 2'b00; we_i = 2'b00;
      #2;
      chk("pre_reset_bus_valid", 32'(bus_valid_o), 32'd1);
      reset_ni = 1'b0;
      #1;
      chk_zero_outputs("async_reset");
      sb.delete();
      e_bv = 1'b0; e_bwe = 1'b0; e_bad = '0; e_bwd = '0;
      @(posedge clk);
      #1;
      reset_ni = 1'b1;
      for (int i = 0; i < 6; i++) apply(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
      apply(mk(2'b11, 2'b00, 32'h160, 32'h260, 0, 0, 2'b01));
      apply(mk(2'b10, 2'b00, 0, 32'h260, 0, 0, 2'b10));
      drain();

      // Long idle: no strobe, bus address holds.
      for (int i = 0; i < 10; i++) apply(mk(2'b00, 2'b00, 0, 0, 0, 0, 2'b00));
      chk("final_scoreboard_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
